cursor_palette_ctrl: RTL
========================

Name: cursor_palette_ctrl

Overview:
- Upstream cursor controller for the palette/cursor path of the paint engine.
- Converts held direction buttons into a 6-bit cursor position (out_x, out_y), with per-axis auto-repeat.
- After every move it emits a strobed offset sweep (plus/sum/c) that the downstream X-scaling stage consumes to compute 9-bit pixel coordinates (4*x ± c).
- Outputs change on posedge clk, so they are stable when the negedge-sampled downstream stage captures them.

Parameters:
- X_MAX, 63, highest legal out_x (≤63).
- Y_MAX, 63, highest legal out_y (≤63).
- REPEAT_DELAY, 24, ticks a button must be held before the first auto-repeat move.
- REPEAT_RATE, 6, ticks between auto-repeat moves after REPEAT_DELAY (≥1, < REPEAT_DELAY).
- C_MAX, 3, largest sweep offset, range 1..7.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  frame-rate strobe, one clk wide.
- btn_left  in  1  synchronized, debounced level.
- btn_right  in  1  as above.
- btn_up  in  1  as above.
- btn_down  in  1  as above.
- out_x  out  6  cursor column.
- out_y  out  6  cursor row.
- plus  out  1  sweep-valid strobe to the downstream stage.
- sum  out  1  1 = add offset, 0 = subtract.
- c  out  3  sweep offset.
- moved  out  1  one-cycle pulse, cursor changed.
- busy  out  1  sweep in progress.

Behaviour:
- Reset: out_x=0, out_y=0, plus=0, sum=0, c=0, moved=0, busy=0, state=IDLE. Hold counters and tick_pend are cleared. Reset takes priority in every state, including mid-sweep; plus is 0 in the cycle after rst is sampled.
- FSM has two states, IDLE and SWEEP.
- IDLE, no tick and no tick_pend: outputs hold; moved=0.
- IDLE, tick or tick_pend: evaluate both axes. tick_pend clears.
- Axis rule: exactly one button of the pair held → a move is due on that tick if it is the press tick (hold count 0), or count==REPEAT_DELAY, or count==REPEAT_DELAY+k*REPEAT_RATE. The count increments on each tick the button stays held.
- Axis rule: neither or both buttons held → no move on that axis, and its hold count resets to 0.
- Left/up decrement; right/down increment.
- Clamp: at 0 a decrement is suppressed; at X_MAX/Y_MAX an increment is suppressed. A suppressed move does not count as a move.
- If at least one axis actually changed, on the same edge:
  - registers update,
  - moved=1 for one cycle,
  - busy=1,
  - plus=1, sum=1, c=0,
  - state→SWEEP.
  Both axes may change on one tick; only one sweep is emitted.
- If nothing changed: remain in IDLE, no sweep.
- SWEEP: one step per clk. The sequence is (sum,c) = (1,0),(1,1)…(1,C_MAX),(0,1)…(0,C_MAX), for 2*C_MAX+1 cycles with plus=1. On the edge after the last step: plus=0, busy=0, sum=0, c=0, state→IDLE.
- out_x and out_y are frozen during SWEEP.
- A tick during SWEEP sets tick_pend (one deep); further ticks while pending are dropped. Hold counts do not advance while pending; they advance when the pending tick is processed.
- Latency: tick sampled at edge n in IDLE → new out_x, moved and the first plus are all visible after edge n.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: boundaries wrap. A decrement at 0 goes to X_MAX/Y_MAX; an increment at the max goes to 0. The wrap is a real move: moved pulses and a sweep follows.
- Undefined: the clamp behaviour above applies.

Test Plan:
- Reset, then idle 20 cycles with ticks and no buttons → out_x=0, out_y=0; plus, moved and busy stay 0.
- out_x=0, btn_right held across one tick → out_x=1 and moved=1 on the next cycle. plus=1 for 7 cycles with (sum,c) = (1,0),(1,1),(1,2),(1,3),(0,1),(0,2),(0,3); then busy=0.
- btn_right held for 40 ticks from out_x=10 (defaults) → moves on ticks 0, 24, 30, 36; final out_x=14; exactly 4 moved pulses.
- out_x=0, btn_left tick → out_x stays 0, no moved, no plus. With CURSOR_WRAP_EN → out_x=63, moved=1, sweep runs.
- btn_left+btn_right together with btn_down → out_x unchanged, out_y+1, a single sweep.
- Tick asserted at sweep step 2 with btn_up held → processed in the first IDLE cycle: out_y-1 and a second sweep. Separately, rst asserted at sweep step 3 → plus=0 and out_x=0 on the next cycle.

Source files
------------

// File: rtl/cursor_palette_ctrl_if.sv
// Button/strobe inputs and cursor/sweep outputs of cursor_palette_ctrl,
// bundled for the controller (slave) and whoever drives it (master).
interface cursor_palette_ctrl_if;
    logic       tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic [5:0] out_x;
    logic [5:0] out_y;
    logic       plus;
    logic       sum;
    logic [2:0] c;
    logic       moved;
    logic       busy;

    modport master (
        output tick, btn_left, btn_right, btn_up, btn_down,
        input  out_x, out_y, plus, sum, c, moved, busy
    );

    modport slave (
        input  tick, btn_left, btn_right, btn_up, btn_down,
        output out_x, out_y, plus, sum, c, moved, busy
    );
endinterface

// File: rtl/cursor_palette_ctrl.sv
// Cursor controller: held buttons -> auto-repeating 6-bit cursor moves, each followed
// by a (sum,c) offset sweep. Define CURSOR_WRAP_EN for wrapping edges instead of clamping.
module cursor_palette_ctrl #(
    parameter int X_MAX        = 63,
    parameter int Y_MAX        = 63,
    parameter int REPEAT_DELAY = 24,
    parameter int REPEAT_RATE  = 6,
    parameter int C_MAX        = 3
) (
    input logic                 clk,
    input logic                 rst,
    cursor_palette_ctrl_if.slave bus
);

    localparam int CW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t          state_q, state_d;
    logic [5:0]      x_q, x_d, y_q, y_d;
    logic [CW-1:0]   cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic            pend_q, pend_d;
    logic            plus_q, plus_d, sum_q, sum_d, moved_q, moved_d, busy_q, busy_d;
    logic [2:0]      c_q, c_d;

    logic            eval, changed, sweep_last;
    logic            dec_x, inc_x, dec_y, inc_y, due_x, due_y;
    logic [5:0]      x_step, y_step;

    function automatic logic [5:0] step_pos(input logic [5:0] pos, input logic dec,
                                            input logic inc, input logic [5:0] maxv);
        step_pos = pos;
        if (inc) begin
            if (pos != maxv) step_pos = pos + 6'd1;
`ifdef CURSOR_WRAP_EN
            else step_pos = '0;
`endif
        end else if (dec) begin
            if (pos != '0) step_pos = pos - 6'd1;
`ifdef CURSOR_WRAP_EN
            else step_pos = maxv;
`endif
        end
    endfunction

    // Count folds back to REPEAT_DELAY every REPEAT_RATE ticks, so "due" is just
    // count==0 or count==REPEAT_DELAY and the counter never overflows.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt, input logic held);
        if (!held)
            cnt_next = '0;
        else if (cnt == CW'(REPEAT_DELAY + REPEAT_RATE - 1))
            cnt_next = CW'(REPEAT_DELAY);
        else
            cnt_next = cnt + CW'(1);
    endfunction

    always_comb begin
        dec_x      = bus.btn_left  & ~bus.btn_right;
        inc_x      = bus.btn_right & ~bus.btn_left;
        dec_y      = bus.btn_up    & ~bus.btn_down;
        inc_y      = bus.btn_down  & ~bus.btn_up;
        due_x      = (dec_x | inc_x) && (cnt_x_q == '0 || cnt_x_q == CW'(REPEAT_DELAY));
        due_y      = (dec_y | inc_y) && (cnt_y_q == '0 || cnt_y_q == CW'(REPEAT_DELAY));
        x_step     = step_pos(x_q, dec_x & due_x, inc_x & due_x, 6'(X_MAX));
        y_step     = step_pos(y_q, dec_y & due_y, inc_y & due_y, 6'(Y_MAX));
        eval       = (state_q == IDLE) && (bus.tick || pend_q);
        changed    = eval && ((x_step != x_q) || (y_step != y_q));
        sweep_last = !sum_q && (c_q == 3'(C_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (changed)    state_d = SWEEP;
            SWEEP:   if (sweep_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        pend_d  = pend_q;
        plus_d  = plus_q;
        sum_d   = sum_q;
        c_d     = c_q;
        busy_d  = busy_q;
        moved_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (eval) begin
                    cnt_x_d = cnt_next(cnt_x_q, dec_x | inc_x);
                    cnt_y_d = cnt_next(cnt_y_q, dec_y | inc_y);
                    pend_d  = 1'b0;
                    if (changed) begin
                        x_d     = x_step;
                        y_d     = y_step;
                        moved_d = 1'b1;
                        plus_d  = 1'b1;
                        sum_d   = 1'b1;
                        c_d     = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            SWEEP: begin
                if (bus.tick) pend_d = 1'b1;
                if (sweep_last) begin
                    plus_d = 1'b0;
                    busy_d = 1'b0;
                    sum_d  = 1'b0;
                    c_d    = '0;
                end else if (c_q == 3'(C_MAX)) begin
                    sum_d = 1'b0;
                    c_d   = 3'd1;
                end else begin
                    c_d = c_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            pend_q  <= 1'b0;
            plus_q  <= 1'b0;
            sum_q   <= 1'b0;
            c_q     <= '0;
            moved_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
            pend_q  <= pend_d;
            plus_q  <= plus_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            moved_q <= moved_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out_x = x_q;
    assign bus.out_y = y_q;
    assign bus.plus  = plus_q;
    assign bus.sum   = sum_q;
    assign bus.c     = c_q;
    assign bus.moved = moved_q;
    assign bus.busy  = busy_q;

endmodule
